// File: rtl/decode_pipe_if.sv
`default_nettype none
// ============================================================================
// decode_pipe_if : fetch/writeback/execute-side signal bundle for decode_pipe
// Rev 1.0
// ============================================================================
interface decode_pipe_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [31:0]     IR_IN;
  logic [XLEN-1:0] NPC_IN;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            RF_WE;
  logic [AW-1:0]   WB_ADDR;
  logic [XLEN-1:0] DATAIN;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [XLEN-1:0] Imm_out;
  logic [XLEN-1:0] NPC_OUT;
  logic [31:0]     IR_OUT;
  logic [AW-1:0]   rd_out;

  modport master (
    output IR_IN, NPC_IN, in_valid, flush, RF_WE, WB_ADDR, DATAIN, out_ready,
    input  in_ready, out_valid, RD1, RD2, Imm_out, NPC_OUT, IR_OUT, rd_out
  );

  modport slave (
    input  IR_IN, NPC_IN, in_valid, flush, RF_WE, WB_ADDR, DATAIN, out_ready,
    output in_ready, out_valid, RD1, RD2, Imm_out, NPC_OUT, IR_OUT, rd_out
  );
endinterface

`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// decode_pipe : RISC-V decode stage - register file, immediate generator and
//               ready/valid ID/EX register with load-use bubble insertion
// Rev 1.0
// ============================================================================
module decode_pipe #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  decode_pipe_if.slave bus
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREGS];

  logic            out_valid_q;
  logic            out_valid_d;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] npc_q;
  logic [31:0]     ir_q;
  logic [AW-1:0]   rd_q;

  // --------------------------------------------------------------------------
  // Instruction format decode
  // --------------------------------------------------------------------------
  logic [31:0]     ir_w;
  logic [2:0]      fmt_w;
  logic            use_rs1_w;
  logic            use_rs2_w;
  logic            has_rd_w;
  logic [AW-1:0]   rs1_w;
  logic [AW-1:0]   rs2_w;
  logic [AW-1:0]   rd_w;
  logic [31:0]     imm32_w;
  logic [XLEN-1:0] imm_w;

  assign ir_w = bus.IR_IN;

  always_comb begin
    fmt_w = FMT_R;
    case (ir_w[6:0])
      OP_OPIMM, OP_OPIMM32, OP_LOAD, OP_JALR: fmt_w = FMT_I;
      OP_STORE:                               fmt_w = FMT_S;
      OP_BRANCH:                              fmt_w = FMT_B;
      OP_LUI, OP_AUIPC:                       fmt_w = FMT_U;
      OP_JAL:                                 fmt_w = FMT_J;
      default:                                fmt_w = FMT_R;
    endcase
  end

  assign use_rs1_w = (fmt_w != FMT_U) && (fmt_w != FMT_J);
  assign use_rs2_w = (fmt_w == FMT_R) || (fmt_w == FMT_S) || (fmt_w == FMT_B);
  assign has_rd_w  = (fmt_w != FMT_S) && (fmt_w != FMT_B);

  assign rs1_w = AW'(ir_w[19:15]);
  assign rs2_w = AW'(ir_w[24:20]);
  assign rd_w  = has_rd_w ? AW'(ir_w[11:7]) : '0;

  // Every immediate fits in 32 bits; widen to XLEN by sign extension.
  always_comb begin
    imm32_w = '0;
    case (fmt_w)
      FMT_I: imm32_w = {{20{ir_w[31]}}, ir_w[31:20]};
      FMT_S: imm32_w = {{20{ir_w[31]}}, ir_w[31:25], ir_w[11:7]};
      FMT_B: imm32_w = {{19{ir_w[31]}}, ir_w[31], ir_w[7], ir_w[30:25],
                        ir_w[11:8], 1'b0};
      FMT_U: imm32_w = {ir_w[31:12], 12'b0};
      FMT_J: imm32_w = {{11{ir_w[31]}}, ir_w[31], ir_w[19:12], ir_w[20],
                        ir_w[30:21], 1'b0};
      default: imm32_w = '0;
    endcase
  end

  assign imm_w = XLEN'($signed(imm32_w));

  // --------------------------------------------------------------------------
  // Register file read ports
  // --------------------------------------------------------------------------
  logic            byp1_w;
  logic            byp2_w;
  logic [XLEN-1:0] rd1_w;
  logic [XLEN-1:0] rd2_w;

  generate
    if (RF_BYPASS) begin : g_bypass
      assign byp1_w = bus.RF_WE && (bus.WB_ADDR == rs1_w);
      assign byp2_w = bus.RF_WE && (bus.WB_ADDR == rs2_w);
    end else begin : g_no_bypass
      assign byp1_w = 1'b0;
      assign byp2_w = 1'b0;
    end
  endgenerate

  always_comb begin
    rd1_w = '0;
    if (rs1_w != '0) begin
      rd1_w = byp1_w ? bus.DATAIN : rf_q[rs1_w];
    end
  end

  always_comb begin
    rd2_w = '0;
    if (rs2_w != '0) begin
      rd2_w = byp2_w ? bus.DATAIN : rf_q[rs2_w];
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and load-use hazard
  // --------------------------------------------------------------------------
  logic held_load_w;
  logic hazard_w;
  logic adv_w;
  logic in_ready_w;
  logic accept_w;

  assign held_load_w = out_valid_q && (ir_q[6:0] == OP_LOAD) && (rd_q != '0);
  assign hazard_w    = held_load_w &&
                       ((use_rs1_w && (rs1_w == rd_q)) ||
                        (use_rs2_w && (rs2_w == rd_q)));
  assign adv_w       = !out_valid_q || bus.out_ready;
  assign in_ready_w  = !rst && adv_w && !hazard_w && !bus.flush;
  assign accept_w    = bus.in_valid && in_ready_w;

  // A hazard with adv set drains the load and leaves a bubble behind it.
  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (adv_w && hazard_w) begin
      out_valid_d = 1'b0;
    end else if (accept_w) begin
      out_valid_d = 1'b1;
    end else if (adv_w) begin
      out_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      npc_q       <= '0;
      ir_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      if (accept_w) begin
        rd1_q <= rd1_w;
        rd2_q <= rd2_w;
        imm_q <= imm_w;
        npc_q <= bus.NPC_IN;
        ir_q  <= ir_w;
        rd_q  <= rd_w;
      end
      if (bus.RF_WE && (bus.WB_ADDR != '0)) begin
        rf_q[bus.WB_ADDR] <= bus.DATAIN;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.RD1       = rd1_q;
  assign bus.RD2       = rd2_q;
  assign bus.Imm_out   = imm_q;
  assign bus.NPC_OUT   = npc_q;
  assign bus.IR_OUT    = ir_q;
  assign bus.rd_out    = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_pipe : directed + randomized bench for decode_pipe against a
//                  behavioural model of the decode stage
// Rev 1.0
// ============================================================================
module tb_decode_pipe;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  localparam int F_R = 0;
  localparam int F_I = 1;
  localparam int F_S = 2;
  localparam int F_B = 3;
  localparam int F_U = 4;
  localparam int F_J = 5;

  localparam bit [6:0] OPS [14] = '{
    7'b0010011, 7'b0011011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b1100111,
    7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
    7'b0111011, 7'b1111111
  };

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  decode_pipe #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .RF_BYPASS (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit last_ready;

  // Reference state
  bit [63:0] m_rf [NREGS];
  bit        m_valid;
  bit [63:0] m_rd1, m_rd2, m_imm, m_npc;
  bit [31:0] m_ir;
  bit [4:0]  m_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fmt_of(bit [31:0] ir);
    case (ir[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: return F_I;
      7'b0100011:                                     return F_S;
      7'b1100011:                                     return F_B;
      7'b0110111, 7'b0010111:                         return F_U;
      7'b1101111:                                     return F_J;
      default:                                        return F_R;
    endcase
  endfunction

  // Interpret the low 'bits' bits of v as a two's complement number.
  function automatic longint sx(longint v, int bits);
    longint m = longint'(1) << bits;
    longint r = v % m;
    if (r >= (m >> 1)) return r - m;
    return r;
  endfunction

  function automatic bit [63:0] imm_of(bit [31:0] ir);
    longint u = longint'({32'b0, ir});
    longint v;
    case (fmt_of(ir))
      F_I: v = sx(u >> 20, 12);
      F_S: v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      F_B: v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                  (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      F_U: v = sx(u & 64'hFFFFF000, 32);
      F_J: v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                  (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic bit [63:0] rf_rd(bit [4:0] s);
    if (s == 0) return 64'd0;
    if (bus.RF_WE && (bus.WB_ADDR == s)) return bus.DATAIN;
    return m_rf[s];
  endfunction

  function automatic bit [31:0] rand_ir();
    bit [31:0] ir = $urandom;
    ir[6:0]   = OPS[$urandom_range(0, 13)];
    ir[19:15] = 5'($urandom_range(0, 5));
    ir[24:20] = 5'($urandom_range(0, 5));
    ir[11:7]  = 5'($urandom_range(0, 5));
    return ir;
  endfunction

  // One cycle: check in_ready against the model, advance both across the edge,
  // then compare every registered output.
  task automatic step();
    int        f;
    bit        u1, u2, haz, adv, rdy, acc;
    bit [31:0] ir;
    bit [4:0]  s1, s2;
    bit [63:0] r1, r2;
    #1;
    ir  = bus.IR_IN;
    f   = fmt_of(ir);
    u1  = (f != F_U) && (f != F_J);
    u2  = (f == F_R) || (f == F_S) || (f == F_B);
    s1  = ir[19:15];
    s2  = ir[24:20];
    r1  = rf_rd(s1);
    r2  = rf_rd(s2);
    haz = m_valid && (m_ir[6:0] == 7'b0000011) && (m_rd != 0) &&
          ((u1 && s1 == m_rd) || (u2 && s2 == m_rd));
    adv = !m_valid || bus.out_ready;
    rdy = !rst && adv && !haz && !bus.flush;
    acc = bus.in_valid && rdy;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    last_ready = bus.in_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_npc = 0; m_ir = 0; m_rd = 0;
      for (int i = 0; i < NREGS; i++) m_rf[i] = 0;
    end else begin
      if (acc) begin
        m_valid = 1;
        m_rd1   = r1;
        m_rd2   = r2;
        m_imm   = imm_of(ir);
        m_npc   = bus.NPC_IN;
        m_ir    = ir;
        m_rd    = (f == F_S || f == F_B) ? 5'd0 : ir[11:7];
      end else if (bus.flush || adv) begin
        m_valid = 0;
      end
      if (bus.RF_WE && bus.WB_ADDR != 0) m_rf[bus.WB_ADDR] = bus.DATAIN;
    end
    #1;
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    chk("RD1", bus.RD1, m_rd1);
    chk("RD2", bus.RD2, m_rd2);
    chk("Imm_out", bus.Imm_out, m_imm);
    chk("NPC_OUT", bus.NPC_OUT, m_npc);
    chk("IR_OUT", {32'd0, bus.IR_OUT}, {32'd0, m_ir});
    chk("rd_out", {59'd0, bus.rd_out}, {59'd0, m_rd});
  endtask

  task automatic drive(input bit r, input bit v, input bit [31:0] ir, input bit [63:0] npc,
                       input bit fl, input bit orr, input bit we, input bit [4:0] wa,
                       input bit [63:0] din);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.IR_IN     = ir;
    bus.NPC_IN    = npc;
    bus.flush     = fl;
    bus.out_ready = orr;
    bus.RF_WE     = we;
    bus.WB_ADDR   = wa;
    bus.DATAIN    = din;
    step();
  endtask

  task automatic wb(input bit [4:0] wa, input bit [63:0] din);
    drive(0, 0, 32'h13, 64'd0, 0, 1, 1, wa, din);
  endtask

  task automatic issue(input bit [31:0] ir, input bit [63:0] npc, input bit orr);
    drive(0, 1, ir, npc, 0, orr, 0, 5'd0, 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.IR_IN     = 32'h13;
    bus.NPC_IN    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.RF_WE     = 1'b0;
    bus.WB_ADDR   = '0;
    bus.DATAIN    = '0;

    drive(1, 1, 32'hff010113, 64'h40, 0, 1, 1, 5'd2, 64'h55);
    drive(1, 0, 32'h13, 64'd0, 0, 1, 0, 5'd0, 64'd0);
    chk("reset_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_ready", {63'd0, last_ready}, 64'd0);

    // addi sp,sp,-16 with sp written the cycle before
    wb(5'd2, 64'h10);
    issue(32'hff010113, 64'h400038, 1);
    chk("addi_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("addi_rd1", bus.RD1, 64'h10);
    chk("addi_imm", bus.Imm_out, 64'hFFFFFFFFFFFFFFF0);
    chk("addi_rd", {59'd0, bus.rd_out}, 64'd2);
    chk("addi_npc", bus.NPC_OUT, 64'h400038);

    issue(32'h100107b7, 64'h40003c, 1);
    chk("lui_imm", bus.Imm_out, 64'h0000000010010000);
    chk("lui_rd", {59'd0, bus.rd_out}, 64'd15);

    wb(5'd11, 64'hAAA1);
    wb(5'd14, 64'hBBB2);
    issue(32'h00e5d463, 64'h400040, 1);
    chk("bge_imm", bus.Imm_out, 64'd8);
    chk("bge_rd", {59'd0, bus.rd_out}, 64'd0);
    chk("bge_rd1", bus.RD1, 64'hAAA1);
    chk("bge_rd2", bus.RD2, 64'hBBB2);

    // sw: each source written in the same cycle it is read
    drive(0, 1, 32'h0106a423, 64'h400044, 0, 1, 1, 5'd16, 64'h01000100);
    chk("sw_byp_rd2", bus.RD2, 64'h01000100);
    chk("sw_imm", bus.Imm_out, 64'd8);
    drive(0, 1, 32'h0106a423, 64'h400048, 0, 1, 1, 5'd13, 64'h20);
    chk("sw_byp_rd1", bus.RD1, 64'h20);
    chk("sw_rd2", bus.RD2, 64'h01000100);

    // load-use: one bubble, then the dependent add goes through
    issue(32'h00052783, 64'h40004c, 1);
    issue(32'h00B78533, 64'h400050, 1);
    chk("lu_ready0", {63'd0, last_ready}, 64'd0);
    chk("lu_bubble", {63'd0, bus.out_valid}, 64'd0);
    issue(32'h00B78533, 64'h400050, 1);
    chk("lu_ready1", {63'd0, last_ready}, 64'd1);
    chk("lu_add_ir", {32'd0, bus.IR_OUT}, 64'h00B78533);
    issue(32'h00052783, 64'h400054, 1);
    issue(32'h00C58533, 64'h400058, 1);
    chk("nodep_ready", {63'd0, last_ready}, 64'd1);
    chk("nodep_ir", {32'd0, bus.IR_OUT}, 64'h00C58533);

    // back-pressure for three cycles
    issue(32'hff010113, 64'h40005c, 1);
    for (int i = 0; i < 3; i++) begin
      issue(32'h100107b7, 64'h400060, 0);
      chk("stall_ready", {63'd0, last_ready}, 64'd0);
      chk("stall_ir", {32'd0, bus.IR_OUT}, 64'hff010113);
    end
    issue(32'h100107b7, 64'h400060, 1);
    chk("release_ready", {63'd0, last_ready}, 64'd1);
    chk("release_ir", {32'd0, bus.IR_OUT}, 64'h100107b7);

    drive(0, 1, 32'h00B78533, 64'h400064, 1, 0, 0, 5'd0, 64'd0);
    chk("flush_ready", {63'd0, last_ready}, 64'd0);
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 8, rand_ir(),
            {$urandom, $urandom}, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    // reset mid-stream with flush, valid and a WB write all active
    wb(5'd1, 64'h1234);
    wb(5'd2, 64'h5678);
    issue(32'h002081b3, 64'h400100, 1);
    drive(1, 1, 32'h002081b3, 64'h400104, 1, 1, 1, 5'd3, 64'hDEAD);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_rd1", bus.RD1, 64'd0);
    chk("rst_ir", {32'd0, bus.IR_OUT}, 64'd0);
    chk("rst_npc", bus.NPC_OUT, 64'd0);
    issue(32'h002081b3, 64'h400108, 1);
    chk("rst_rf_x1", bus.RD1, 64'd0);
    chk("rst_rf_x2", bus.RD2, 64'd0);
    chk("rst_after_valid", {63'd0, bus.out_valid}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_pipe.md
# decode_pipe

Parametrised RISC-V decode stage with register file, full immediate generator, and a ready/valid ID/EX pipeline register. Sits between fetch (IR/NPC) and execute, taking writeback data from WB. Generalises the fixed 64-bit decode unit with configurable XLEN and register count, same-cycle write-to-read bypass, back-pressure, flush, and one-bubble load-use hazard stalls.

## Interface
- XLEN, 64: datapath width, 32 or 64.
- NREGS, 32: architectural registers; index width AW = $clog2(NREGS).
- RF_BYPASS, 1: 1 forwards a same-cycle WB write to the read ports; 0 gives read-old-value.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- IR_IN  in  32  instruction from fetch.
- NPC_IN  in  XLEN  next PC from fetch.
- in_valid  in  1  IR_IN/NPC_IN valid.
- in_ready  out  1  decode accepts this cycle.
- flush  in  1  kill the held instruction and any incoming one (branch redirect).
- RF_WE  in  1  writeback enable.
- WB_ADDR  in  AW  writeback register index.
- DATAIN  in  XLEN  writeback data.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes this cycle.
- RD1, RD2  out  XLEN  registered rs1/rs2 operands.
- Imm_out  out  XLEN  registered sign-extended immediate.
- NPC_OUT  out  XLEN  registered NPC.
- IR_OUT  out  32  registered instruction.
- rd_out  out  AW  registered destination index, 0 when the format has no rd.

## Operation
- Register file: NREGS x XLEN. Written on clk when RF_WE and WB_ADDR != 0. x0 always reads 0.
- Reads are combinational from IR_IN[19:15] and IR_IN[24:20]. With RF_BYPASS=1, if RF_WE and WB_ADDR equals a nonzero rs, the read returns DATAIN.
- Format by opcode IR[6:0]:
  - I: 0010011, 0011011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, 0111011.
  - Any other opcode: immediate 0, treated as R.
- Immediates are sign-extended from IR[31] to XLEN. U immediate is {IR[31:12], 12'b0} sign-extended. B and J immediates have LSB 0.
- Register usage:
  - rs1 is used by every format except U and J.
  - rs2 is used by R, S and B.
  - rd is meaningful for R, I, U and J, otherwise 0.
- Handshake:
  - adv = !out_valid | out_ready.
  - in_ready = adv & !hazard & !flush.
  - Accept when in_valid & in_ready.
- Hazard: asserted when out_valid, the held opcode is 0000011, rd_out != 0, and an rs used by IR_IN equals rd_out.
- ID/EX update, in priority order:
  - rst: clear all.
  - flush: out_valid <= 0.
  - adv & hazard: out_valid <= 0 (inserts one bubble).
  - accept: load all output registers, out_valid <= 1.
  - adv with no accept: out_valid <= 0.
  - Otherwise hold all output registers.

## Timing
- Reset: out_valid, RD1, RD2, Imm_out, NPC_OUT, IR_OUT and rd_out all 0; every register-file entry 0. in_ready = 0 while rst is high.
- Latency: instruction accepted at edge N appears on the outputs after edge N, with out_valid=1.
- Throughput: one instruction per cycle when out_ready stays high and there is no hazard.
- Stall (out_valid & !out_ready): all outputs hold. in_ready=0.
- Load-use: exactly one bubble. The dependent instruction is accepted on the next cycle with in_ready=1, once the load has left the register.
- A WB write and a dependent read in the same cycle see DATAIN when RF_BYPASS=1.
- flush together with in_valid: the input is dropped and out_valid=0 next cycle.
- rst asserted mid-operation: the next edge clears everything regardless of flush, handshake or RF_WE.

## Test plan
- Reset, then write x2=0x10 via WB. Then IR_IN=0xff010113, NPC_IN=0x400038 -> next cycle out_valid=1, RD1=0x10, Imm_out=0xFFFFFFFFFFFFFFF0, rd_out=2, NPC_OUT=0x400038.
- IR_IN=0x100107b7 (lui a5) -> Imm_out=0x0000000010010000, rd_out=15. IR_IN=0x00e5d463 -> Imm_out=8, rd_out=0, RD1=x11, RD2=x14.
- Write x16=0x01000100 and x13=0x20 in the same cycles as the corresponding reads of IR_IN=0x0106a423 (sw) -> RD2=0x01000100, RD1=0x20 via bypass, Imm_out=8.
- Back-to-back 0x00052783 (lw a5,0(a0)) then 0x00B78533 (add a0,a5,a1) with out_ready=1 -> in_ready=0 for one cycle, one out_valid=0 bubble, then add emitted. Repeat with a non-dependent add -> no bubble.
- Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Release -> pending instruction accepted on the next cycle.
- Assert flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the input is not accepted. Assert rst mid-stream -> all outputs 0 and the register file reads 0.
